// File: rtl/residual_adder_pipe.sv
// rtl/residual_adder_pipe.sv - per-lane dequantise/add/round/saturate residual adder, 5 stages + output reg
// Define RESADD_SAT_CNT_EN to add the sat_cnt output (count of output beats with any saturated lane).
module residual_adder_pipe #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int SW    = 10,
  parameter int SHW   = 5,
  parameter int AW    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_vld,
  output logic                cfg_rdy,
  input  logic [SW-1:0]       scale_a,
  input  logic [SW-1:0]       scale_b,
  input  logic [SHW-1:0]      shift,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [LANES*DW-1:0] in_data_a,
  input  logic [LANES*DW-1:0] in_data_b,
  input  logic [AW-1:0]       in_addr,
  input  logic                in_last,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [LANES*DW-1:0] out_data,
  output logic [AW-1:0]       out_addr,
  output logic                out_last
`ifdef RESADD_SAT_CNT_EN
  ,
  output logic [15:0]         sat_cnt
`endif
);
  localparam int PW = DW + SW + 1;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (DW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  logic [SW-1:0]            scale_a_q, scale_b_q;
  logic [SHW-1:0]           shift_q;
  logic [4:0]               vld_q;
  logic [4:0][AW-1:0]       addr_q;
  logic [4:0]               last_q;
  logic [LANES-1:0][DW-1:0] s1_a_q, s1_b_q;
  logic [LANES-1:0][PW-1:0] s2_pa_q, s2_pb_q, s2_pa_d, s2_pb_d;
  logic [LANES-1:0][PW:0]   s3_sum_q, s3_sum_d;
  logic [LANES-1:0][PW:0]   s4_sh_q, s4_sh_d;
  logic [LANES-1:0]         s4_r_q, s4_r_d;
  logic [LANES-1:0][DW-1:0] s5_res_q, s5_res_d;
  logic                     out_vld_q, out_last_q;
  logic [LANES*DW-1:0]      out_data_q;
  logic [AW-1:0]            out_addr_q;
  logic                     adv, cfg_take;
`ifdef RESADD_SAT_CNT_EN
  logic                     s5_sat_d, s5_sat_q, out_sat_q;
  logic [15:0]              sat_cnt_q;
`endif

  // One shared advance for every stage: any output stall freezes the whole pipe.
  assign adv      = ~out_vld_q | out_rdy;
  assign in_rdy   = adv;
  assign cfg_rdy  = ~(|vld_q | out_vld_q) & ~in_vld;
  assign cfg_take = cfg_vld & cfg_rdy;

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_addr = out_addr_q;
  assign out_last = out_last_q;

  always_comb begin
    logic signed [PW-1:0] ea, eb, esa, esb;
    logic signed [PW:0]   sm, rt;
    logic signed [RW-1:0] rs;
    logic [SHW-1:0]       sh_m1;
    ea = '0; eb = '0; esa = '0; esb = '0; sm = '0; rt = '0; rs = '0;
    s2_pa_d  = '0;
    s2_pb_d  = '0;
    s3_sum_d = '0;
    s4_sh_d  = '0;
    s4_r_d   = '0;
    s5_res_d = '0;
`ifdef RESADD_SAT_CNT_EN
    s5_sat_d = 1'b0;
`endif
    sh_m1 = shift_q - SHW'(1);
    esa   = {{(PW-SW){1'b0}}, scale_a_q};
    esb   = {{(PW-SW){1'b0}}, scale_b_q};
    for (int i = 0; i < LANES; i++) begin
      ea = {{(PW-DW){s1_a_q[i][DW-1]}}, s1_a_q[i]};
      eb = {{(PW-DW){s1_b_q[i][DW-1]}}, s1_b_q[i]};
      s2_pa_d[i] = ea * esa;
      s2_pb_d[i] = eb * esb;
      s3_sum_d[i] = {s2_pa_q[i][PW-1], s2_pa_q[i]} + {s2_pb_q[i][PW-1], s2_pb_q[i]};
      // Shifting by shift-1 saturates to the sign bit once past the MSB, giving the round bit.
      sm = s3_sum_q[i];
      s4_sh_d[i] = sm >>> shift_q;
      rt = sm >>> sh_m1;
      s4_r_d[i] = (shift_q != '0) && rt[0];
      rs = {s4_sh_q[i][PW], s4_sh_q[i]} + RW'(s4_r_q[i]);
      if (rs > SAT_MAX)      s5_res_d[i] = SAT_MAX[DW-1:0];
      else if (rs < SAT_MIN) s5_res_d[i] = SAT_MIN[DW-1:0];
      else                   s5_res_d[i] = rs[DW-1:0];
`ifdef RESADD_SAT_CNT_EN
      if (rs > SAT_MAX || rs < SAT_MIN) s5_sat_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_a_q  <= '0;
      scale_b_q  <= '0;
      shift_q    <= '0;
      vld_q      <= '0;
      addr_q     <= '0;
      last_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_pa_q    <= '0;
      s2_pb_q    <= '0;
      s3_sum_q   <= '0;
      s4_sh_q    <= '0;
      s4_r_q     <= '0;
      s5_res_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (cfg_take) begin
        scale_a_q <= scale_a;
        scale_b_q <= scale_b;
        shift_q   <= shift;
      end
      if (adv) begin
        vld_q      <= {vld_q[3:0], in_vld};
        addr_q     <= {addr_q[3:0], in_addr};
        last_q     <= {last_q[3:0], in_last};
        s1_a_q     <= in_data_a;
        s1_b_q     <= in_data_b;
        s2_pa_q    <= s2_pa_d;
        s2_pb_q    <= s2_pb_d;
        s3_sum_q   <= s3_sum_d;
        s4_sh_q    <= s4_sh_d;
        s4_r_q     <= s4_r_d;
        s5_res_q   <= s5_res_d;
        out_vld_q  <= vld_q[4];
        out_data_q <= s5_res_q;
        out_addr_q <= addr_q[4];
        out_last_q <= last_q[4];
      end
    end
  end

`ifdef RESADD_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s5_sat_q  <= 1'b0;
      out_sat_q <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (adv) begin
        s5_sat_q  <= s5_sat_d;
        out_sat_q <= s5_sat_q;
      end
      if (cfg_take)
        sat_cnt_q <= '0;
      else if (out_vld_q && out_rdy && out_sat_q && sat_cnt_q != 16'hFFFF)
        sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_residual_adder_pipe.sv
// tb/tb_residual_adder_pipe.sv - scoreboard testbench for residual_adder_pipe
module tb_residual_adder_pipe;
  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int SW    = 10;
  localparam int SHW   = 5;
  localparam int AW    = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_vld, cfg_rdy;
  logic [SW-1:0]       scale_a, scale_b;
  logic [SHW-1:0]      shift;
  logic                in_vld, in_rdy;
  logic [LANES*DW-1:0] in_data_a, in_data_b;
  logic [AW-1:0]       in_addr;
  logic                in_last;
  logic                out_vld, out_rdy;
  logic [LANES*DW-1:0] out_data;
  logic [AW-1:0]       out_addr;
  logic                out_last;
`ifdef RESADD_SAT_CNT_EN
  logic [15:0]         sat_cnt;
`endif

  always #5 clk = ~clk;

  residual_adder_pipe #(
    .LANES(LANES), .DW(DW), .SW(SW), .SHW(SHW), .AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_vld  (cfg_vld),
    .cfg_rdy  (cfg_rdy),
    .scale_a  (scale_a),
    .scale_b  (scale_b),
    .shift    (shift),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data_a(in_data_a),
    .in_data_b(in_data_b),
    .in_addr  (in_addr),
    .in_last  (in_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
`ifdef RESADD_SAT_CNT_EN
    ,
    .sat_cnt  (sat_cnt)
`endif
  );

  typedef struct {
    logic [LANES*DW-1:0] data;
    logic [AW-1:0]       addr;
    logic                last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    m_sa = 0, m_sb = 0, m_sh = 0;

  // Round-half-up written as floor((p + 2^(sh-1)) / 2^sh), then clamp.
  function automatic logic [DW-1:0] model_lane(input int a, input int b, input int sa, input int sbv, input int sh);
    longint p, r;
    p = longint'(a) * sa + longint'(b) * sbv;
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    if (r > 127)       r = 127;
    else if (r < -128) r = -128;
    return r[DW-1:0];
  endfunction

  function automatic logic [LANES*DW-1:0] model_vec(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++)
      v[i*DW +: DW] = model_lane(int'($signed(a[i*DW +: DW])), int'($signed(b[i*DW +: DW])), m_sa, m_sb, m_sh);
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected addr=%0h data=%h required no beat", out_addr, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_addr !== mon_e.addr || out_last !== mon_e.last) begin
          errors++;
          $display("FAIL sb_beat got addr=%0h last=%0b data=%h required addr=%0h last=%0b data=%h",
                   out_addr, out_last, out_data, mon_e.addr, mon_e.last, mon_e.data);
        end
      end
    end
  end

  task automatic send(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                      input logic [AW-1:0] addr, input logic last);
    int    n;
    beat_t e;
    in_vld = 1'b1; in_data_a = a; in_data_b = b; in_addr = addr; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 100) begin @(negedge clk); n++; end
    if (!in_rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout addr=%0h in_rdy=%0b required 1", addr, in_rdy);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    e.data = model_vec(a, b); e.addr = addr; e.last = last;
    sb.push_back(e);
    #1 in_vld = 1'b0;
  endtask

  task automatic do_cfg(input int sa, input int sbv, input int sh, output int n);
    cfg_vld = 1'b1; scale_a = SW'(sa); scale_b = SW'(sbv); shift = SHW'(sh);
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_rdy && n < 200);
    if (!cfg_rdy) begin
      checks++; errors++;
      $display("FAIL cfg_timeout cfg_rdy=%0b required 1", cfg_rdy);
      cfg_vld = 1'b0;
      return;
    end
    @(posedge clk);
    m_sa = sa; m_sb = sbv; m_sh = sh;
    #1 cfg_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_vld) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b0)  begin errors++; $display("FAIL rst_out_vld got=%0b required 0", out_vld); end
    checks++; if (out_data !== '0)   begin errors++; $display("FAIL rst_out_data got=%h required 0", out_data); end
    checks++; if (out_addr !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL rst_sideband got=%0h/%0b required 0/0", out_addr, out_last); end
    checks++; if (in_rdy !== 1'b1 || cfg_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%0b/%0b required 1/1", in_rdy, cfg_rdy); end
    rst = 1'b0;
    m_sa = 0; m_sb = 0; m_sh = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [LANES*DW-1:0] a, b;
    int n;
    do_cfg(64, 64, 6, n);
    a = rand_vec(); b = rand_vec();
    a[DW-1:0] = 8'd10; b[DW-1:0] = 8'd20;
    send(a, b, 9'h1A5, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k < 5) begin
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_early k=%0d out_vld=%0b required 0", k, out_vld); end
      end
    end
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL basic_latency out_vld=%0b required 1", out_vld); end
    checks++; if (out_data[DW-1:0] !== 8'd30) begin errors++; $display("FAIL basic_lane0 got=%0d required 30", out_data[DW-1:0]); end
    checks++; if (out_addr !== 9'h1A5 || out_last !== 1'b1) begin errors++; $display("FAIL basic_sideband got=%0h/%0b required 1a5/1", out_addr, out_last); end
    drain();
  endtask

  task automatic test_rounding();
    logic [LANES*DW-1:0] a, b;
    logic [DW-1:0] ain[3];
    logic [DW-1:0] rexp[3];
    int n;
    ain[0] = 8'd3; ain[1] = 8'd2; ain[2] = 8'hFD;
    rexp[0] = 8'd2; rexp[1] = 8'd1; rexp[2] = 8'hFF;
    do_cfg(1, 0, 1, n);
    for (int i = 0; i < 3; i++) begin
      a = rand_vec(); b = rand_vec();
      a[DW-1:0] = ain[i];
      send(a, b, AW'(16 + i), 1'b0);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_vld && n < 20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_vld !== 1'b1 || out_data[DW-1:0] !== rexp[i]) begin
        errors++;
        $display("FAIL round_lane0 beat=%0d got=%0h vld=%0b required %0h", i, out_data[DW-1:0], out_vld, rexp[i]);
      end
      if (i < 2) @(negedge clk);
    end
    drain();
  endtask

  task automatic test_saturation();
    logic [LANES*DW-1:0] a, b;
    int n;
    do_cfg(1023, 1023, 0, n);
    a = {LANES{8'd127}}; b = {LANES{8'd127}};
    send(a, b, 9'd32, 1'b0);
    a = {LANES{8'h80}}; b = {LANES{8'h80}};
    send(a, b, 9'd33, 1'b0);
    for (int i = 0; i < 2; i++) begin
      a = rand_vec(); b = rand_vec();
      a[DW-1:0] = 8'd100; b[DW-1:0] = 8'd100;
      send(a, b, AW'(34 + i), i == 1);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_vld && n < 20);
    checks++; if (out_data[DW-1:0] !== 8'd127) begin errors++; $display("FAIL sat_pos got=%0h required 7f", out_data[DW-1:0]); end
    @(negedge clk);
    checks++; if (out_data[DW-1:0] !== 8'h80) begin errors++; $display("FAIL sat_neg got=%0h required 80", out_data[DW-1:0]); end
    drain();
`ifdef RESADD_SAT_CNT_EN
    checks++; if (sat_cnt !== 16'd4) begin errors++; $display("FAIL sat_cnt got=%0d required 4", sat_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    do_cfg(3, 5, 2, n);
    fork
      begin
        for (int i = 0; i < 20; i++) send(rand_vec(), rand_vec(), AW'(i), i == 19);
      end
      begin
        logic [LANES*DW-1:0] snap;
        int bad_rdy, bad_hold;
        bad_rdy = 0; bad_hold = 0;
        repeat (8) @(posedge clk);
        #1 out_rdy = 1'b0;
        @(negedge clk);
        snap = out_data;
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_stall_vld got=%0b required 1", out_vld); end
        repeat (9) begin
          @(negedge clk);
          if (in_rdy !== 1'b0) bad_rdy++;
          if (out_data !== snap) bad_hold++;
        end
        checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL bp_in_rdy cycles_high=%0d required 0", bad_rdy); end
        checks++; if (bad_hold != 0) begin errors++; $display("FAIL bp_hold cycles_changed=%0d required 0", bad_hold); end
        @(posedge clk);
        #1 out_rdy = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_cfg_guard();
    logic [LANES*DW-1:0] a, b;
    int n;
    do_cfg(4, 0, 0, n);
    for (int i = 0; i < 3; i++) begin
      a = rand_vec(); b = rand_vec();
      a[DW-1:0] = DW'(5 + i);
      send(a, b, AW'(64 + i), 1'b0);
    end
    do_cfg(4, 0, 3, n);
    checks++; if (n != 7) begin errors++; $display("FAIL cfg_guard_wait got=%0d cycles required 7", n); end
    a = rand_vec(); b = rand_vec();
    a[DW-1:0] = 8'd20;
    send(a, b, 9'd70, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_vld && n < 20);
    checks++; if (out_data[DW-1:0] !== 8'd10) begin errors++; $display("FAIL cfg_guard_new got=%0d required 10", out_data[DW-1:0]); end
    drain();
  endtask

  task automatic test_reset_midstream();
    logic [LANES*DW-1:0] a, b;
    int n;
    do_cfg(5, 7, 1, n);
    for (int i = 0; i < 4; i++) send(rand_vec(), rand_vec(), AW'(80 + i), 1'b0);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got=%0b required 0", out_vld); end
    checks++; if (out_data !== '0)  begin errors++; $display("FAIL mid_rst_data got=%h required 0", out_data); end
    rst = 1'b0;
    m_sa = 0; m_sb = 0; m_sh = 0;
    a = rand_vec(); b = rand_vec();
    a[DW-1:0] = 8'd100; b[DW-1:0] = 8'd50;
    send(a, b, 9'd90, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_vld && n < 20);
    checks++; if (out_vld !== 1'b1 || out_data !== '0) begin errors++; $display("FAIL mid_rst_zero got=%h vld=%0b required 0/1", out_data, out_vld); end
    repeat (15) @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required finish before", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; scale_a = '0; scale_b = '0; shift = '0;
    in_vld = 1'b0; in_data_a = '0; in_data_b = '0; in_addr = '0; in_last = 1'b0;
    out_rdy = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_cfg_guard();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
